tcam_kv_engine: RTL

TCAM_KV_ENGINE -- requirements
Module: tcam_kv_engine

---
 rtl/tcam_kv_engine.sv | 136 +++++++++++++
 1 files changed

// File: rtl/tcam_kv_engine.sv
// Ternary CAM with associated values and a two-stage lookup pipeline.
// Lowest matching index wins; writes/invalidates/flushes are posted in order.
module tcam_kv_engine #(
  parameter  int KEY_WIDTH   = 32,
  parameter  int DEPTH       = 16,
  parameter  int VALUE_WIDTH = 32,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [AW-1:0]          req_addr,
  input  logic [KEY_WIDTH-1:0]   req_key,
  input  logic [KEY_WIDTH-1:0]   req_mask,
  input  logic [VALUE_WIDTH-1:0] req_value,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_hit,
  output logic [AW-1:0]          resp_addr,
  output logic [VALUE_WIDTH-1:0] resp_value,
  output logic [31:0]            lookup_cnt,
  output logic [31:0]            hit_cnt
);

  localparam logic [1:0] OP_LKP = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_INV = 2'b10;
  localparam logic [1:0] OP_FL  = 2'b11;

  logic [DEPTH-1:0]       r_vld;
  logic [KEY_WIDTH-1:0]   r_key [DEPTH];
  logic [KEY_WIDTH-1:0]   r_msk [DEPTH];
  logic [VALUE_WIDTH-1:0] r_val [DEPTH];

  logic                   r_s1_v;
  logic [KEY_WIDTH-1:0]   r_s1_key;
  logic                   r_s2_v;
  logic                   r_s2_hit;
  logic [AW-1:0]          r_s2_addr;
  logic [VALUE_WIDTH-1:0] r_s2_val;
  logic [31:0]            r_lkp_cnt;
  logic [31:0]            r_hit_cnt;

  logic                   w_adv;
  logic                   w_acc;
  logic                   w_lkp;
  logic [DEPTH-1:0]       w_match;
  logic                   w_hit;
  logic [AW-1:0]          w_idx;
  logic [VALUE_WIDTH-1:0] w_val;

  assign w_adv = !r_s2_v || resp_ready;
  assign w_acc = req_valid && w_adv;
  assign w_lkp = w_acc && (req_op == OP_LKP);

  // Scan high to low so the lowest matching index is left standing.
  always_comb begin
    w_match = '0;
    w_hit   = 1'b0;
    w_idx   = '0;
    w_val   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      w_match[i] = r_vld[i] &&
        (((r_s1_key ^ r_key[i]) & ~r_msk[i]) == '0);
      if (w_match[i]) begin
        w_hit = 1'b1;
        w_idx = AW'(i);
        w_val = r_val[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_key[i] <= '0;
        r_msk[i] <= '0;
        r_val[i] <= '0;
      end
    end else if (w_acc) begin
      unique case (req_op)
        OP_WR: begin
          r_vld[req_addr] <= 1'b1;
          r_key[req_addr] <= req_key;
          r_msk[req_addr] <= req_mask;
          r_val[req_addr] <= req_value;
        end
        OP_INV: r_vld[req_addr] <= 1'b0;
        OP_FL:  r_vld <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_v    <= 1'b0;
      r_s1_key  <= '0;
      r_s2_v    <= 1'b0;
      r_s2_hit  <= 1'b0;
      r_s2_addr <= '0;
      r_s2_val  <= '0;
    end else if (w_adv) begin
      r_s1_v <= w_lkp;
      if (w_lkp) r_s1_key <= req_key;
      r_s2_v    <= r_s1_v;
      r_s2_hit  <= r_s1_v && w_hit;
      r_s2_addr <= r_s1_v ? w_idx : '0;
      r_s2_val  <= r_s1_v ? w_val : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lkp_cnt <= '0;
      r_hit_cnt <= '0;
    end else begin
      if (w_lkp && (r_lkp_cnt != '1))
        r_lkp_cnt <= r_lkp_cnt + 32'd1;
      if (w_adv && r_s1_v && w_hit && (r_hit_cnt != '1))
        r_hit_cnt <= r_hit_cnt + 32'd1;
    end
  end

  assign req_ready  = w_adv;
  assign resp_valid = r_s2_v;
  assign resp_hit   = r_s2_hit;
  assign resp_addr  = r_s2_addr;
  assign resp_value = r_s2_val;
  assign lookup_cnt = r_lkp_cnt;
  assign hit_cnt    = r_hit_cnt;

endmodule
